// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame-number poller: FSM encoding,
// field widths and the saturating skip-counter adder.
package cam_pkg;

  localparam int FRAME_W = 8;
  localparam int SKIP_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2
  } cam_state_e;

  // Adds an 8-bit increment to the skip counter, pinning at all-ones.
  function automatic logic [SKIP_W-1:0] sat_add(input logic [SKIP_W-1:0]  a,
                                                 input logic [FRAME_W-1:0] b);
    logic [SKIP_W:0] sum;
    sum = {1'b0, a} + {{(SKIP_W + 1 - FRAME_W){1'b0}}, b};
    return sum[SKIP_W] ? {SKIP_W{1'b1}} : sum[SKIP_W-1:0];
  endfunction

endpackage

// File: rtl/poll_timer.sv
// Free-running poll divider: counts 0..POLL_DIV-1 while en is high and
// emits tick on the last count; held at zero while en is low.
module poll_timer #(
  parameter int unsigned POLL_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(POLL_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (!en) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
      tick    = 1'b1;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cam_frame_poller.sv
// Periodically reads a camera frame-number register over Avalon-MM and
// tracks the latest frame, new-frame events and a count of missed frames.
module cam_frame_poller
  import cam_pkg::*;
#(
  parameter int unsigned POLL_DIV   = 1000,
  parameter int unsigned FRAME_ADDR = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                clear_stats,
  output logic [2:0]          avm_address,
  output logic                avm_read,
  input  logic [31:0]         avm_readdata,
  output logic [FRAME_W-1:0]  frame_num,
  output logic                frame_valid,
  output logic                new_frame,
  output logic [SKIP_W-1:0]   skipped_cnt
);

  // Handshake: the slave has no waitrequest and a fixed read latency of one,
  // so a one-cycle avm_read in RD always yields valid readdata during CAP.

  cam_state_e         state_q, state_d;
  logic [FRAME_W-1:0] frame_num_q, frame_num_d;
  logic               frame_valid_q, frame_valid_d;
  logic               new_frame_q, new_frame_d;
  logic [SKIP_W-1:0]  skipped_q, skipped_d;
  logic               avm_read_q, avm_read_d;
  logic               tick;
  logic [FRAME_W-1:0] sample;
  logic [FRAME_W-1:0] delta;
  logic               unused_readdata_hi;

  assign unused_readdata_hi = ^avm_readdata[31:FRAME_W];

  poll_timer #(
    .POLL_DIV (POLL_DIV)
  ) u_poll_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (enable && (state_q == IDLE)),
    .tick    (tick)
  );

  always_comb begin
    state_d       = state_q;
    frame_num_d   = frame_num_q;
    frame_valid_d = frame_valid_q;
    new_frame_d   = 1'b0;
    skipped_d     = skipped_q;
    sample        = avm_readdata[FRAME_W-1:0];
    delta         = sample - frame_num_q;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = RD;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        // The read always finishes once issued, even if enable dropped.
        state_d = IDLE;
        if (!frame_valid_q) begin
          frame_num_d   = sample;
          frame_valid_d = 1'b1;
        end else if (delta != '0) begin
          frame_num_d = sample;
          new_frame_d = 1'b1;
          skipped_d   = sat_add(skipped_q, delta - FRAME_W'(1));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear takes priority over any increment landing on the same edge.
    if (clear_stats) begin
      skipped_d = '0;
    end

    avm_read_d = (state_d == RD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      frame_num_q   <= '0;
      frame_valid_q <= 1'b0;
      new_frame_q   <= 1'b0;
      skipped_q     <= '0;
      avm_read_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_num_q   <= frame_num_d;
      frame_valid_q <= frame_valid_d;
      new_frame_q   <= new_frame_d;
      skipped_q     <= skipped_d;
      avm_read_q    <= avm_read_d;
    end
  end

  assign avm_address = 3'(FRAME_ADDR);
  assign avm_read    = avm_read_q;
  assign frame_num   = frame_num_q;
  assign frame_valid = frame_valid_q;
  assign new_frame   = new_frame_q;
  assign skipped_cnt = skipped_q;

endmodule
